puf_key_gen: RTL

PUF_KEY_GEN -- requirements
Module: puf_key_gen

---
 rtl/puf_pkg.sv | 19 +
 rtl/puf_gen_64.sv | 24 ++
 rtl/puf_tmv_acc.sv | 34 +++
 rtl/puf_key_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF key generator: FSM states, slice width,
// and the vote-counter width helper.
package puf_pkg;

  localparam int SLICE_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } puf_state_e;

  // Enough bits to count every sample without wrapping.
  function automatic int vote_cnt_w(input int num_samples);
    return $clog2(num_samples + 1);
  endfunction

endpackage

// File: rtl/puf_gen_64.sv
// Behavioural stand-in for one 64-bit PUF slice: a fixed 0xA5 fingerprint,
// tagged with the slice index and the challenge, and all-zero when disabled.
module puf_gen_64 #(
  parameter int SLICE_ID = 0
) (
  input  logic        enable,
  input  logic [1:0]  challenge,
  output logic [63:0] response
);

  localparam logic [63:0] BASE = {8{8'hA5}};

  logic [63:0] tag;

  assign tag = {48'd0, 8'(SLICE_ID), 6'd0, challenge};

  always_comb begin
    response = '0;
    if (enable) begin
      response = BASE ^ tag;
    end
  end

endmodule

// File: rtl/puf_tmv_acc.sv
// Per-bit ones-counter and majority compare for temporal majority voting.
// Only compiled when PUF_TMV_EN is defined.
`ifdef PUF_TMV_EN
module puf_tmv_acc
  import puf_pkg::*;
#(
  parameter int NUM_SAMPLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample_en,
  input  logic bit_in,
  output logic vote
);

  localparam int CNT_W = vote_cnt_w(NUM_SAMPLES);

  logic [CNT_W-1:0] ones_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_reg <= '0;
    end else if (clear) begin
      ones_reg <= '0;
    end else if (sample_en && bit_in) begin
      ones_reg <= ones_reg + 1'b1;
    end
  end

  assign vote = (ones_reg > CNT_W'(NUM_SAMPLES / 2));

endmodule
`endif

// File: rtl/puf_key_gen.sv
// PUF response generator: settle the PUF, sample it, and register the response.
// PUF_TMV_EN enables temporal majority voting over NUM_SAMPLES samples per bit.
module puf_key_gen
  import puf_pkg::*;
#(
  parameter int  NUM_SLICES    = 4,
  parameter int  SETTLE_CYCLES = 16,
  parameter int  NUM_SAMPLES   = 7,
  localparam int RESP_W        = SLICE_W * NUM_SLICES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        challenge,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic              busy
);

`ifdef PUF_TMV_EN
  localparam bit TMV_EN = 1'b1;
`else
  localparam bit TMV_EN = 1'b0;
`endif
  localparam int VOTE_SAMPLES = TMV_EN ? NUM_SAMPLES : 1;

  puf_state_e        state_reg;
  logic [7:0]        settle_cnt_reg;
  logic [3:0]        sample_cnt_reg;
  logic [1:0]        chal_reg;
  logic              puf_en_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              busy_reg;
  logic [RESP_W-1:0] resp_data_reg;

  wire  [RESP_W-1:0] raw_resp;
  wire  [RESP_W-1:0] vote_vec;
  logic              req_fire;
  logic              sample_en;

  assign req_fire  = req_valid && req_ready_reg;
  // Samples are taken for VOTE_SAMPLES cycles; the extra SAMPLE cycle registers the result.
  assign sample_en = (state_reg == SAMPLE) && (sample_cnt_reg < 4'(VOTE_SAMPLES));

  genvar gi;

  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : gen_slice
      puf_gen_64 #(
        .SLICE_ID (gi)
      ) u_puf (
        .enable    (puf_en_reg),
        .challenge (chal_reg),
        .response  (raw_resp[gi*SLICE_W +: SLICE_W])
      );
    end
  endgenerate

`ifdef PUF_TMV_EN
  generate
    for (gi = 0; gi < RESP_W; gi++) begin : gen_vote
      puf_tmv_acc #(
        .NUM_SAMPLES (NUM_SAMPLES)
      ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (req_fire),
        .sample_en (sample_en),
        .bit_in    (raw_resp[gi]),
        .vote      (vote_vec[gi])
      );
    end
  endgenerate
`else
  logic [RESP_W-1:0] raw_sample_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_sample_reg <= '0;
    end else if (req_fire) begin
      raw_sample_reg <= '0;
    end else if (sample_en) begin
      raw_sample_reg <= raw_resp;
    end
  end

  assign vote_vec = raw_sample_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      sample_cnt_reg <= '0;
      chal_reg       <= '0;
      puf_en_reg     <= 1'b0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            state_reg      <= SETTLE;
            chal_reg       <= challenge;
            settle_cnt_reg <= '0;
            sample_cnt_reg <= '0;
            puf_en_reg     <= 1'b1;
            req_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == 8'(SETTLE_CYCLES - 1)) begin
            state_reg      <= SAMPLE;
            sample_cnt_reg <= '0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        SAMPLE: begin
          if (sample_cnt_reg == 4'(VOTE_SAMPLES)) begin
            state_reg      <= DONE;
            resp_data_reg  <= vote_vec;
            resp_valid_reg <= 1'b1;
            puf_en_reg     <= 1'b0;
          end else begin
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // The state only returns to IDLE here, so a request in this cycle waits for IDLE.
          if (resp_valid_reg && resp_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            req_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign busy       = busy_reg;

endmodule
